ws2812_rx: RTL and testbench



---
 rtl/ws2812_rx_if.sv | 28 ++
 rtl/ws2812_rx.sv | 188 ++++++++++++++++++
 tb/tb_ws2812_rx.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ws2812_rx_if.sv
// Decoded-output bundle of the WS2812 receiver: pixel strobe, frame strobe and sticky error flags.
// The receiver drives it through the master modport; consumers use the slave modport.
interface ws2812_rx_if #(
  parameter int unsigned MAX_PIX = 64
);
  localparam int unsigned IdxW = (MAX_PIX > 1) ? $clog2(MAX_PIX) : 1;
  localparam int unsigned CntW = $clog2(MAX_PIX) + 1;

  logic            pixel_valid;
  logic [23:0]     pixel_data;
  logic [IdxW-1:0] pixel_idx;
  logic            frame_done;
  logic [CntW-1:0] pix_count;
  logic            err_glitch;
  logic            err_stuck;
  logic            err_partial;
  logic            err_overrun;

  modport master (
    output pixel_valid, pixel_data, pixel_idx, frame_done, pix_count,
    output err_glitch, err_stuck, err_partial, err_overrun
  );

  modport slave (
    input pixel_valid, pixel_data, pixel_idx, frame_done, pix_count,
    input err_glitch, err_stuck, err_partial, err_overrun
  );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 NRZ receiver: measures high/low widths of the synchronized line in clk cycles and
// rebuilds 24-bit GRB pixels and frame boundaries, flagging glitches, stuck lines and short frames.
module ws2812_rx #(
  parameter int unsigned CLK_FRE   = 50_000_000,
  parameter int unsigned TH_NS     = 600,
  parameter int unsigned GLITCH_NS = 150,
  parameter int unsigned MAXH_NS   = 2000,
  parameter int unsigned RST_US    = 50,
  parameter int unsigned MAX_PIX   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ws2812_di_i,
  ws2812_rx_if.master rx_o
);

  // 64-bit arithmetic: CLK_FRE * ns overflows 32 bits at ordinary clock rates.
  localparam longint unsigned ClkL   = longint'(CLK_FRE);
  localparam int unsigned     Th     = 32'(ClkL * TH_NS / 64'd1_000_000_000);
  localparam int unsigned     Glitch = 32'(ClkL * GLITCH_NS / 64'd1_000_000_000);
  localparam int unsigned     MaxH   = 32'(ClkL * MAXH_NS / 64'd1_000_000_000);
  localparam int unsigned     Rst    = 32'(ClkL * RST_US / 64'd1_000_000);

  localparam int unsigned HW   = $clog2(MaxH + 2);
  localparam int unsigned LW   = $clog2(Rst + 1);
  localparam int unsigned IdxW = (MAX_PIX > 1) ? $clog2(MAX_PIX) : 1;
  localparam int unsigned CntW = $clog2(MAX_PIX) + 1;

  localparam logic [HW-1:0]   ThC      = HW'(Th);
  localparam logic [HW-1:0]   GlitchC  = HW'(Glitch);
  localparam logic [HW-1:0]   MaxHC    = HW'(MaxH);
  localparam logic [LW-1:0]   RstC     = LW'(Rst);
  localparam logic [CntW-1:0] MaxPixC  = CntW'(MAX_PIX);
  localparam logic [IdxW-1:0] LastIdxC = IdxW'(MAX_PIX - 1);

  typedef enum logic [1:0] {StSync, StIdle, StHigh, StLow} state_e;

  // Input synchronizer plus one delayed copy for edge detection.
  logic sync1_q, sync2_q, prev_q;
  logic line, rise, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= ws2812_di_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign line = sync2_q;
  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  state_e          state_q;
  logic [HW-1:0]   hcnt_q;
  logic [LW-1:0]   lcnt_q;
  logic [4:0]      bit_cnt_q;
  logic [23:0]     shift_q;
  logic [CntW-1:0] pix_q;
  logic            emit_q;

  logic            pixel_valid_q;
  logic [23:0]     pixel_data_q;
  logic [IdxW-1:0] pixel_idx_q;
  logic            frame_done_q;
  logic [CntW-1:0] pix_count_q;
  logic            err_glitch_q, err_stuck_q, err_partial_q, err_overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StSync;
      hcnt_q        <= '0;
      lcnt_q        <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      pix_q         <= '0;
      emit_q        <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_data_q  <= '0;
      pixel_idx_q   <= '0;
      frame_done_q  <= 1'b0;
      pix_count_q   <= '0;
      err_glitch_q  <= 1'b0;
      err_stuck_q   <= 1'b0;
      err_partial_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;

      // Emit runs beside the FSM so a rising edge in the same cycle is still taken.
      if (emit_q) begin
        emit_q        <= 1'b0;
        pixel_valid_q <= 1'b1;
        pixel_data_q  <= shift_q;
        if (pix_q >= MaxPixC) begin
          err_overrun_q <= 1'b1;
          pixel_idx_q   <= LastIdxC;
        end else begin
          pixel_idx_q <= pix_q[IdxW-1:0];
          pix_q       <= pix_q + 1'b1;
        end
      end

      unique case (state_q)
        StSync: begin
          if (line) begin
            lcnt_q <= '0;
          end else if (lcnt_q == RstC) begin
            state_q <= StIdle;
          end else begin
            lcnt_q <= lcnt_q + 1'b1;
          end
        end

        StIdle: begin
          if (rise) begin
            state_q   <= StHigh;
            hcnt_q    <= HW'(1);
            bit_cnt_q <= '0;
            pix_q     <= '0;
          end
        end

        StHigh: begin
          if (hcnt_q > MaxHC) begin
            err_stuck_q <= 1'b1;
            state_q     <= StSync;
            lcnt_q      <= '0;
          end else if (fall) begin
            if (hcnt_q < GlitchC) begin
              err_glitch_q <= 1'b1;
              state_q      <= StSync;
              lcnt_q       <= '0;
            end else begin
              shift_q <= {shift_q[22:0], (hcnt_q >= ThC)};
              if (bit_cnt_q == 5'd23) begin
                bit_cnt_q <= '0;
                emit_q    <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
              state_q <= StLow;
              lcnt_q  <= LW'(1);
            end
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end

        StLow: begin
          if (lcnt_q == RstC) begin
            frame_done_q <= 1'b1;
            pix_count_q  <= pix_q;
            if (bit_cnt_q != '0) begin
              err_partial_q <= 1'b1;
            end
            bit_cnt_q <= '0;
            pix_q     <= '0;
            state_q   <= StIdle;
          end else if (rise) begin
            state_q <= StHigh;
            hcnt_q  <= HW'(1);
          end else begin
            lcnt_q <= lcnt_q + 1'b1;
          end
        end

        default: state_q <= StSync;
      endcase
    end
  end

  assign rx_o.pixel_valid = pixel_valid_q;
  assign rx_o.pixel_data  = pixel_data_q;
  assign rx_o.pixel_idx   = pixel_idx_q;
  assign rx_o.frame_done  = frame_done_q;
  assign rx_o.pix_count   = pix_count_q;
  assign rx_o.err_glitch  = err_glitch_q;
  assign rx_o.err_stuck   = err_stuck_q;
  assign rx_o.err_partial = err_partial_q;
  assign rx_o.err_overrun = err_overrun_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: directed line waveforms push expected pixels/frames into queues and a
// negedge monitor pops and compares whenever the receiver strobes.
module tb_ws2812_rx;

  localparam int unsigned MaxPix   = 4;
  localparam int          PixLat   = 4;
  localparam int          FrameLat = 2503;

  logic clk = 1'b0;
  logic rst_n;
  logic di;

  ws2812_rx_if #(.MAX_PIX(MaxPix)) rx_if ();

  ws2812_rx #(.MAX_PIX(MaxPix)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ws2812_di_i (di),
    .rx_o        (rx_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int last_fall = 0;
  int checks = 0;
  int failures = 0;

  logic [23:0] exp_data_q[$];
  int          exp_idx_q[$];
  int          exp_cnt_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_if.pixel_valid) begin
        if (exp_data_q.size() == 0) begin
          check("unexpected_pixel", 32'd1, 32'd0);
        end else begin
          check("pixel_data", 32'(rx_if.pixel_data), 32'(exp_data_q.pop_front()));
          check("pixel_idx", 32'(rx_if.pixel_idx), 32'(exp_idx_q.pop_front()));
          check("pixel_latency", 32'(cyc - last_fall), 32'(PixLat));
        end
      end
      if (rx_if.frame_done) begin
        if (exp_cnt_q.size() == 0) begin
          check("unexpected_frame_done", 32'd1, 32'd0);
        end else begin
          check("pix_count", 32'(rx_if.pix_count), 32'(exp_cnt_q.pop_front()));
          check("frame_latency", 32'(cyc - last_fall), 32'(FrameLat));
        end
      end
    end
  end

  task automatic send_bit(input int h, input int l);
    di = 1'b1;
    repeat (h) @(posedge clk);
    #1 di = 1'b0;
    last_fall = cyc;
    repeat (l) @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input logic [23:0] d, input bit push, input int idx);
    if (push) begin
      exp_data_q.push_back(d);
      exp_idx_q.push_back(idx);
    end
    for (int i = 23; i >= 0; i--) send_bit(d[i] ? 40 : 20, d[i] ? 22 : 42);
  endtask

  task automatic gap(input int n);
    di = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_errs(input string tag, input logic [3:0] exp);
    check({tag, "_err_glitch"},  32'(rx_if.err_glitch),  32'(exp[3]));
    check({tag, "_err_stuck"},   32'(rx_if.err_stuck),   32'(exp[2]));
    check({tag, "_err_partial"}, 32'(rx_if.err_partial), 32'(exp[1]));
    check({tag, "_err_overrun"}, 32'(rx_if.err_overrun), 32'(exp[0]));
  endtask

  initial begin
    rst_n = 1'b0;
    di    = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_pixel_valid", 32'(rx_if.pixel_valid), 32'd0);
    check("rst_pixel_data", 32'(rx_if.pixel_data), 32'd0);
    check("rst_pixel_idx", 32'(rx_if.pixel_idx), 32'd0);
    check("rst_frame_done", 32'(rx_if.frame_done), 32'd0);
    check("rst_pix_count", 32'(rx_if.pix_count), 32'd0);
    check_errs("rst", 4'b0000);
    rst_n = 1'b1;
    gap(2600);

    // Full frame: pixel k = {k, A5, 3C}.
    for (int k = 0; k < MaxPix; k++) send_pixel({8'(k), 8'hA5, 8'h3C}, 1'b1, k);
    exp_cnt_q.push_back(MaxPix);
    gap(2600);
    check_errs("frame", 4'b0000);

    // Threshold edges: 29->0, 30->1, 7->0 (legal), 100->1 (legal), last bit 1.
    exp_data_q.push_back(24'h500001);
    exp_idx_q.push_back(0);
    for (int i = 0; i < 24; i++) begin
      send_bit((i == 0) ? 29 : (i == 1) ? 30 : (i == 2) ? 7 : (i == 3) ? 100 :
               (i == 23) ? 40 : 20, 30);
    end
    exp_cnt_q.push_back(1);
    gap(2600);
    check_errs("thresh", 4'b0000);

    // Glitch: 6-cycle high aborts the pixel; nothing decodes until a full gap.
    send_bit(40, 22);
    send_bit(20, 42);
    send_bit(6, 30);
    check("glitch_flag", 32'(rx_if.err_glitch), 32'd1);
    for (int i = 0; i < 21; i++) send_bit(40, 22);
    gap(2600);
    send_pixel(24'hC0FFEE, 1'b1, 0);
    exp_cnt_q.push_back(1);
    gap(2600);

    // Stuck high for 101 cycles.
    send_bit(101, 30);
    check("stuck_flag", 32'(rx_if.err_stuck), 32'd1);
    gap(2600);
    send_pixel(24'h123456, 1'b1, 0);
    exp_cnt_q.push_back(1);
    gap(2600);

    // Partial frame: 3 pixels + 10 bits.
    check("partial_before", 32'(rx_if.err_partial), 32'd0);
    for (int k = 0; k < 3; k++) send_pixel({8'h10 + 8'(k), 8'h5A, 8'hC3}, 1'b1, k);
    for (int i = 0; i < 10; i++) send_bit(40, 22);
    exp_cnt_q.push_back(3);
    gap(2600);
    check("partial_after", 32'(rx_if.err_partial), 32'd1);

    // Overrun: MaxPix+1 pixels; last one reports index MaxPix-1.
    check("overrun_before", 32'(rx_if.err_overrun), 32'd0);
    for (int k = 0; k <= MaxPix; k++) begin
      send_pixel({8'h80 + 8'(k), 8'h0F, 8'hF0}, 1'b1, (k < MaxPix) ? k : MaxPix - 1);
    end
    exp_cnt_q.push_back(MaxPix);
    gap(2600);
    check("overrun_after", 32'(rx_if.err_overrun), 32'd1);

    // Reset released mid-frame (bit 5 of pixel 2): nothing decodes until a full gap.
    rst_n = 1'b0;
    fork
      begin
        for (int k = 0; k < 3; k++) send_pixel(24'hFFFFFF, 1'b0, 0);
      end
      begin
        repeat ((2 * 24 + 5) * 62 + 10) @(posedge clk);
        #2 rst_n = 1'b1;
      end
    join
    check_errs("midrst", 4'b0000);
    gap(2600);
    send_pixel(24'hAA55AA, 1'b1, 0);
    send_pixel(24'h00FF01, 1'b1, 1);
    exp_cnt_q.push_back(2);
    gap(2600);
    check_errs("midrst_end", 4'b0000);

    check("pixels_outstanding", 32'(exp_data_q.size()), 32'd0);
    check("frames_outstanding", 32'(exp_cnt_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
